debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel input conditioner: each of `N` asynchronous raw inputs (switches, keys) is synchronised, debounced over a programmable stable period, and edge-detected. Per-channel event counters count debounced edges in a selectable mode, and per-channel glitch counters count aborted debounce attempts. Sits between board I/O pins and any logic consuming clean single-cycle edge events or display counts. It supersedes the separate single-channel synchroniser, debouncer, transition-detector and counter chain.

## Interface
Parameters:
- `N`, 4, number of independent channels (≥1)
- `PERIOD`, 500000, debounce stable time in clock cycles (10 ms at 50 MHz); legal range ≥2
- `CNT_W`, 8, width of each event and glitch counter
- `SATURATE`, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at 2^CNT_W−1

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high; clears every register
- `in`  in  N  raw asynchronous inputs
- `mode`  in  2  event select, shared by all channels: 00 both edges, 01 rising only, 10 falling only, 11 none
- `clr`  in  1  synchronous clear of all event and glitch counters
- `stable`  out  N  debounced level per channel
- `rise`  out  N  one-cycle pulse on debounced 0→1
- `fall`  out  N  one-cycle pulse on debounced 1→0
- `event`  out  N  `rise`/`fall` gated by `mode`
- `count`  out  N*CNT_W  packed event counters; channel i at [i*CNT_W +: CNT_W]
- `glitch`  out  N*CNT_W  packed glitch counters; same packing

## Operation
- Per channel, a 2-flop synchroniser `s1`→`s2` feeds the debouncer. Both flops reset to 0.
- Debouncer holds `stable` and a counter `dc` of width $clog2(PERIOD+1), both reset to 0.
  - `s2 == stable`: `dc` ← 0.
  - `s2 != stable`: `dc` ← `dc`+1.
  - When the incremented value equals `PERIOD`: `stable` toggles and `dc` ← 0 in the same edge.
- Glitch detect: `s2 == stable` while `dc != 0` is an aborted attempt. The glitch counter increments once on that edge.
- Edge outputs come from `stable` and a one-cycle-delayed copy `stable_q` (reset 0):
  - `rise` = `stable & ~stable_q`
  - `fall` = `~stable & stable_q`
  - Both outputs are pure functions of registers, so they are glitch-free.
- `event[i]` = (mode==00: `rise|fall`; 01: `rise`; 10: `fall`; 11: 0).
  - `mode` is combinational into `event`, so a change affects the same cycle.
- Event counter i increments on a clock edge where `event[i]`=1. The glitch counter increments as defined above.
- Counter overflow:
  - `SATURATE`=0: all-ones + 1 → 0.
  - `SATURATE`=1: all-ones holds.
- `clr`=1 zeroes all counters on that edge.
  - `clr` has priority: an increment in the same cycle is dropped.
  - `clr` does not affect `stable`, `dc` or the synchronisers.
- Channels are fully independent. Simultaneous events on several channels each count.
- After reset, `stable`=0. An input held high through reset release produces one debounced rise, and that rise is counted if the mode allows it.

## Timing
- Reset values: all outputs 0, including `stable`, `rise`, `fall`, `event`, `count` and `glitch`.
- `rst` asserted mid-debounce aborts the attempt immediately (asynchronously) and does not count as a glitch.
- Latency: `in` changes and is then held. Counting the first rising edge that samples the new value as edge 1:
  - `stable` updates on edge `PERIOD`+2.
  - `rise`/`fall`/`event` are high for exactly the cycle after that edge.
  - `count` updates on the next edge (`PERIOD`+3).
- A pulse on `in` that lasts fewer than `PERIOD` cycles, as seen at `s2`, never changes `stable` and increments `glitch` by 1 when it ends.
- A pulse that reaches exactly `PERIOD` cycles at `s2` is accepted.
- Minimum spacing between consecutive debounced edges on one channel is `PERIOD` cycles. Consequently `rise` and `fall` are never both high on a channel.

## Test plan
Bench uses `PERIOD`=8, `N`=4, `CNT_W`=4.

- Reset release with `in`=0000 → all outputs 0. Hold `in[0]`=1 → `stable[0]` rises on edge 10, `rise[0]`/`event[0]` high for 1 cycle, `count[0]`=1 on edge 11.
- `in[1]` bounces 1,0,1,0 with 3-cycle phases, then held at 1 → `glitch[1]`=2, exactly one `rise[1]`, `count[1]`=1.
- `mode`=01, channel 2 toggled 0→1→0 with long holds → `rise` and `fall` each pulse once, `count[2]`=1. Repeat with `mode`=10 → `count[2]`=2. With `mode`=11 → count unchanged.
- 17 both-edge events on channel 3 → `count[3]`=1 with `SATURATE`=0; `count[3]`=15 with `SATURATE`=1.
- `clr` asserted in the same cycle as `event[0]` → `count[0]`=0 afterwards. A debounce in progress still completes on schedule.
- `rst` pulsed while `dc` is mid-count on channel 1 → all outputs 0 immediately, and `glitch[1]` stays 0.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank
//
// Multi-channel input conditioner. Each raw asynchronous input is passed
// through a two-flop synchroniser, debounced over PERIOD stable cycles and
// edge-detected. Per-channel counters record debounced edge events, filtered
// by a shared mode. A second set of per-channel counters records aborted
// debounce attempts (glitches).
//
// Parameters
//   N        number of channels (>= 1)
//   PERIOD   cycles the synchronised input must differ from the debounced
//            level before the level is accepted (>= 2)
//   CNT_W    width of each event and glitch counter
//   SATURATE 0: counters wrap, 1: counters stick at all-ones
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset, clears every register
//   in      [N]          raw asynchronous inputs
//   mode    [2]          event select: 00 both, 01 rise, 10 fall, 11 none
//   clr     synchronous clear of all event and glitch counters
//   stable  [N]          debounced level per channel
//   rise    [N]          one-cycle pulse on debounced 0->1
//   fall    [N]          one-cycle pulse on debounced 1->0
//   evt     [N]          rise/fall gated by mode (combinational in mode)
//   count   [N*CNT_W]    event counters, channel i at [i*CNT_W +: CNT_W]
//   glitch  [N*CNT_W]    glitch counters, same packing
module debounce_bank #(
    parameter int N        = 4,
    parameter int PERIOD   = 500000,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in,
    input  logic [1:0]         mode,
    input  logic               clr,
    output logic [N-1:0]       stable,
    output logic [N-1:0]       rise,
    output logic [N-1:0]       fall,
    output logic [N-1:0]       evt,
    output logic [N*CNT_W-1:0] count,
    output logic [N*CNT_W-1:0] glitch
);

    localparam int              DC_W     = $clog2(PERIOD + 1);
    localparam logic [DC_W-1:0] PERIOD_C = DC_W'(PERIOD);

    // Counter increment with optional saturation at all-ones.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if ((SATURATE != 0) && (&v)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Mode gating is combinational so a mode change affects the same cycle.
    always_comb begin
        evt = '0;
        case (mode)
            2'b00:   evt = rise | fall;
            2'b01:   evt = rise;
            2'b10:   evt = fall;
            default: evt = '0;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             stb;
        logic             stb_q;
        logic [DC_W-1:0]  dc;
        logic [DC_W-1:0]  dc_inc;
        logic             abort;
        logic [CNT_W-1:0] ev_cnt;
        logic [CNT_W-1:0] gl_cnt;

        assign dc_inc = dc + DC_W'(1);
        // Input fell back to the debounced level before PERIOD was reached.
        assign abort  = (s2 == stb) && (dc != '0);

        // Stage: synchroniser
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= in[i];
                s2 <= s1;
            end
        end

        // Stage: debouncer
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stb <= 1'b0;
                dc  <= '0;
            end else if (s2 == stb) begin
                dc <= '0;
            end else if (dc_inc == PERIOD_C) begin
                stb <= ~stb;
                dc  <= '0;
            end else begin
                dc <= dc_inc;
            end
        end

        // Stage: edge detect
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stb_q <= 1'b0;
            end else begin
                stb_q <= stb;
            end
        end

        // Stage: counters, clear takes priority over any increment
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ev_cnt <= '0;
                gl_cnt <= '0;
            end else if (clr) begin
                ev_cnt <= '0;
                gl_cnt <= '0;
            end else begin
                if (evt[i]) begin
                    ev_cnt <= cnt_inc(ev_cnt);
                end
                if (abort) begin
                    gl_cnt <= cnt_inc(gl_cnt);
                end
            end
        end

        assign stable[i]                   = stb;
        assign rise[i]                     = stb & ~stb_q;
        assign fall[i]                     = ~stb & stb_q;
        assign count[i*CNT_W +: CNT_W]     = ev_cnt;
        assign glitch[i*CNT_W +: CNT_W]    = gl_cnt;
    end

endmodule
